// File: rtl/extmem_pkg.sv
// External-memory responder shared definitions: region bases, region enum, address decode.
// Decode is purely combinational; callers pass region size and region count.
// No backpressure here; see extmem_model for acceptance.
package extmem_pkg;

  localparam logic [63:0] OFFSET_INF_CONV = 64'd0;
  localparam logic [63:0] OFFSET_FMI      = 64'd2  << 20;
  localparam logic [63:0] OFFSET_FMO      = 64'd4  << 20;
  localparam logic [63:0] OFFSET_KEX      = 64'd6  << 20;
  localparam logic [63:0] OFFSET_KPW      = 64'd26 << 20;
  localparam logic [63:0] OFFSET_KDW      = 64'd44 << 20;

  localparam logic [63:0] BASE [6] = '{
    OFFSET_INF_CONV, OFFSET_FMI, OFFSET_FMO, OFFSET_KEX, OFFSET_KPW, OFFSET_KDW
  };

  typedef enum logic [2:0] {
    REG_INF_CONV = 3'd0,
    REG_FMI      = 3'd1,
    REG_FMO      = 3'd2,
    REG_KEX      = 3'd3,
    REG_KPW      = 3'd4,
    REG_KDW      = 3'd5
  } region_e;

  typedef struct packed {
    logic        hit;
    region_e     region;
    logic [63:0] offset;
  } decode_t;

  // Scan from the highest region down so the lowest matching region is the one left standing.
  function automatic decode_t extmem_decode(input logic [63:0] addr,
                                            input logic [63:0] region_words,
                                            input int          n_regions);
    decode_t d;
    d.hit    = 1'b0;
    d.region = REG_INF_CONV;
    d.offset = '0;
    for (int i = 5; i >= 0; i--) begin
      if (i < n_regions && addr >= BASE[i] && (addr - BASE[i]) < region_words) begin
        d.hit    = 1'b1;
        d.region = region_e'(3'(i));
        d.offset = addr - BASE[i];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/extmem_if.sv
// Request/response bus between the DMA-side requester and the external-memory responder.
// Zero latency (wires only).
// Requester holds a request while ready_extmem is low.
interface extmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              request_extmem;
  logic              write_extmem;
  logic [ADDR_W-1:0] addr_extmem;
  logic [DATA_W-1:0] w_data;
  logic              valid_extmem;
  logic [DATA_W-1:0] data_extmem;
  logic              ready_extmem;

  modport master (
    output request_extmem, write_extmem, addr_extmem, w_data,
    input  valid_extmem, data_extmem, ready_extmem
  );

  modport slave (
    input  request_extmem, write_extmem, addr_extmem, w_data,
    output valid_extmem, data_extmem, ready_extmem
  );
endinterface

// File: rtl/extmem_rd_pipe.sv
// RD_LAT-stage valid/data shift register for read returns; final data stage holds the last word.
// Latency RD_LAT cycles from in_vld to out_vld.
// No backpressure; synchronous rst flushes every stage.
module extmem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  // Shift valids every cycle; a data stage only loads when its input is valid, so the
  // last stage keeps the most recently returned word between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      if (in_vld) dat[0] <= in_dat;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_vld = vld[RD_LAT-1];
  assign out_dat = dat[RD_LAT-1];

endmodule

// File: rtl/extmem_model.sv
// External-memory responder: region-decoded word storage with preload port, monitors, counters.
// Read data returns RD_LAT cycles after acceptance; writes land on the acceptance edge.
// ready_extmem is constant 1, or LFSR-driven stalls when EXTMEM_STALL_EN is defined.
module extmem_model
  import extmem_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 32,
  parameter int          REGION_WORDS = 4096,
  parameter int          N_REGIONS    = 6,
  parameter int          RD_LAT       = 1,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  extmem_if.slave           bus,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              err_unmapped,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = N_REGIONS * REGION_WORDS;
  localparam int IDX_W = $clog2(DEPTH);

  // Reject configurations the storage layout and stall generator cannot honour.
  if (RD_LAT < 1 || N_REGIONS < 1 || N_REGIONS > 6 ||
      (REGION_WORDS & (REGION_WORDS - 1)) != 0 || STALL_SEED == 16'h0000) begin : g_bad_cfg
    $error("extmem_model: illegal parameter set");
  end

  function automatic logic [IDX_W-1:0] to_idx(input decode_t d);
    return IDX_W'({61'd0, d.region} * 64'(REGION_WORDS) + d.offset);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  decode_t           bus_dec;
  decode_t           init_dec;
  logic [IDX_W-1:0]  bus_idx;
  logic [IDX_W-1:0]  init_idx;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] rd_word;

  assign bus_dec  = extmem_decode(64'(bus.addr_extmem), 64'(REGION_WORDS), N_REGIONS);
  assign init_dec = extmem_decode(64'(init_addr), 64'(REGION_WORDS), N_REGIONS);
  assign bus_idx  = to_idx(bus_dec);
  assign init_idx = to_idx(init_dec);

  assign rd_acc  = bus.request_extmem & ~bus.write_extmem & bus.ready_extmem;
  assign wr_acc  = bus.request_extmem &  bus.write_extmem & bus.ready_extmem;
  assign rd_word = bus_dec.hit ? mem[bus_idx] : '0;

`ifdef EXTMEM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16/14/13/11, restarted from the seed on every reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= STALL_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bus.ready_extmem = (lfsr[1:0] != 2'b00);
`else
  assign bus.ready_extmem = 1'b1;
`endif

  // Storage write; an accepted bus write takes priority over a same-cycle preload. Not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && bus_dec.hit) begin
      mem[bus_idx] <= bus.w_data;
    end else if (init_we && init_dec.hit) begin
      mem[init_idx] <= init_data;
    end
  end

  // Traffic counters and the sticky unmapped-access flag (preload traffic is not monitored).
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unmapped <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      if (rd_acc) rd_count <= rd_count + 32'd1;
      if (wr_acc) wr_count <= wr_count + 32'd1;
      if ((rd_acc || wr_acc) && !bus_dec.hit) err_unmapped <= 1'b1;
    end
  end

  extmem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_acc),
    .in_dat  (rd_word),
    .out_vld (bus.valid_extmem),
    .out_dat (bus.data_extmem)
  );

endmodule
